// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package matmul_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working width of the narrowing helper; must exceed every accumulator and result width
    localparam int unsigned MAX_W = 128;

    // Range-check outcome: out-of-range flag plus the clamped value (low bits are the result)
    typedef struct packed {
        logic             oor;
        logic [MAX_W-1:0] val;
    } narrow_t;

    // Accumulator width: full product plus enough guard bits for N additions (at least one)
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        int unsigned extra;
        extra = (n > 1) ? $clog2(n) : 1;
        return 2 * dw + extra;
    endfunction

    // Check v (already sign/zero extended to MAX_W) against an ow-bit range and clamp it
    function automatic narrow_t narrow(input logic [MAX_W-1:0] v, input int unsigned ow,
                                       input logic sgn);
        narrow_t          r;
        logic [MAX_W-1:0] hi;
        logic [MAX_W-1:0] lo;
        r = '0;
        if (sgn) begin
            hi = (MAX_W'(1) << (ow - 1)) - MAX_W'(1);
            lo = ~hi;
            if ($signed(v) > $signed(hi)) begin
                r.oor = 1'b1;
                r.val = hi;
            end else if ($signed(v) < $signed(lo)) begin
                r.oor = 1'b1;
                r.val = lo;
            end else begin
                r.val = v;
            end
        end else begin
            hi = (MAX_W'(1) << ow) - MAX_W'(1);
            if (v > hi) begin
                r.oor = 1'b1;
                r.val = hi;
            end else begin
                r.val = v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane: acc += a*b, with the narrowed view of acc+a*b (MATMUL_SAT_EN selects clamp, else wrap).
// Latency: result/out_of_range are combinational from acc and operands; acc updates one cycle later.
// Backpressure: none; the lane advances whenever enable is high, clear takes priority.
module matmul_mac_lane
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic [OUT_WIDTH-1:0]  result,
    output logic                  out_of_range
);

    logic [ACC_WIDTH-1:0]            acc_q;
    logic signed [DATA_WIDTH:0]      a_ext;
    logic signed [DATA_WIDTH:0]      b_ext;
    logic signed [2*DATA_WIDTH+1:0]  prod;
    logic [ACC_WIDTH-1:0]            sum;
    logic [MAX_W-1:0]                sum_ext;
    narrow_t                         nr;
    logic                            narrow_unused;

    // Extend operands by one bit so a single signed multiplier serves both modes, then add to acc
    always_comb begin
        a_ext = $signed({signed_mode & a[DATA_WIDTH-1], a});
        b_ext = $signed({signed_mode & b[DATA_WIDTH-1], b});
        prod  = a_ext * b_ext;
        sum   = acc_q + ACC_WIDTH'(prod);
        if (signed_mode) begin
            sum_ext = {{(MAX_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
        end else begin
            sum_ext = {{(MAX_W-ACC_WIDTH){1'b0}}, sum};
        end
        nr = narrow(sum_ext, OUT_WIDTH, signed_mode);
    end

    // Narrowed output: clamp when saturation is built in, otherwise keep the low bits
    always_comb begin
`ifdef MATMUL_SAT_EN
        result = nr.val[OUT_WIDTH-1:0];
`else
        result = sum_ext[OUT_WIDTH-1:0];
`endif
        out_of_range  = nr.oor;
        narrow_unused = ^nr.val;
    end

    // Accumulator: cleared at job start and after each output write, else accumulates
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= sum;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Sequential C = A x B engine: LANES columns per cycle, signed/unsigned per job, narrowing to OUT_WIDTH (MATMUL_SAT_EN: clamp).
// Latency: T = M*N*P/LANES compute cycles; busy from start+1, done pulses start+T+1, idle again at start+T+2.
// Backpressure: none; start is only taken in IDLE, requests while busy are dropped.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned M          = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned P          = 8,
    parameter int unsigned LANES      = 1,
    parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [M*N*DATA_WIDTH-1:0]     matrix_a,
    input  logic [N*P*DATA_WIDTH-1:0]     matrix_b,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [M*P*OUT_WIDTH-1:0]      result_c
);

    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, N);
    localparam int unsigned JG        = P / LANES;
    localparam int unsigned IW        = (M > 1)  ? $clog2(M)  : 1;
    localparam int unsigned JW        = (JG > 1) ? $clog2(JG) : 1;
    localparam int unsigned KW        = (N > 1)  ? $clog2(N)  : 1;
    localparam int unsigned AIW       = $clog2(M * N * DATA_WIDTH);
    localparam int unsigned BIW       = $clog2(N * P * DATA_WIDTH);
    localparam int unsigned RIW       = $clog2(M * P * OUT_WIDTH);

    state_t                        state_q, state_d;
    logic [M*N*DATA_WIDTH-1:0]     a_q;
    logic [N*P*DATA_WIDTH-1:0]     b_q;
    logic                          mode_q;
    logic [IW-1:0]                 i_q;
    logic [JW-1:0]                 jg_q;
    logic [KW-1:0]                 k_q;
    logic [M*P*OUT_WIDTH-1:0]      result_q;
    logic                          overflow_q;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic                          accept, calc, wr_en, lane_clear;
    logic                          k_last, jg_last, i_last, job_last;
    logic [DATA_WIDTH-1:0]         a_sel;
    logic [DATA_WIDTH-1:0]         b_sel    [LANES];
    logic [RIW-1:0]                res_idx  [LANES];
    logic [OUT_WIDTH-1:0]          lane_res [LANES];
    logic [ACC_WIDTH-1:0]          lane_acc [LANES];
    logic [LANES-1:0]              lane_oor;
    logic                          acc_unused;

    assign k_last   = (k_q == KW'(N - 1));
    assign jg_last  = (jg_q == JW'(JG - 1));
    assign i_last   = (i_q == IW'(M - 1));
    assign job_last = k_last && jg_last && i_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the final (i, jg, k) step ends CALC, DONE lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (job_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: job acceptance, compute enables and next values of the status flags
    always_comb begin
        accept     = (state_q == IDLE) && start;
        calc       = (state_q == CALC);
        wr_en      = calc && k_last;
        lane_clear = accept || wr_en;
        busy_d     = (state_q != IDLE);
        done_d     = (state_q == DONE);
    end

    // Status flags are registered so busy/done trail the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operand snapshot taken on acceptance so callers may change inputs mid-job
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            a_q    <= matrix_a;
            b_q    <= matrix_b;
            mode_q <= signed_mode;
        end
    end

    // Loop counters: k fastest, then column group jg, then row i
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            i_q  <= '0;
            jg_q <= '0;
            k_q  <= '0;
        end else if (calc) begin
            if (k_last) begin
                k_q <= '0;
                if (jg_last) begin
                    jg_q <= '0;
                    i_q  <= i_last ? '0 : i_q + 1'b1;
                end else begin
                    jg_q <= jg_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Operand fetch: A[i][k] is shared, each lane takes B[k][jg*LANES+l] and owns C[i][jg*LANES+l]
    always_comb begin
        int unsigned a_idx;
        int unsigned b_idx;
        int unsigned r_idx;
        a_idx = (32'(i_q) * N + 32'(k_q)) * DATA_WIDTH;
        a_sel = a_q[AIW'(a_idx) +: DATA_WIDTH];
        for (int unsigned l = 0; l < LANES; l++) begin
            b_idx      = (32'(k_q) * P + 32'(jg_q) * LANES + l) * DATA_WIDTH;
            r_idx      = (32'(i_q) * P + 32'(jg_q) * LANES + l) * OUT_WIDTH;
            b_sel[l]   = b_q[BIW'(b_idx) +: DATA_WIDTH];
            res_idx[l] = RIW'(r_idx);
        end
    end

    // Lane accumulators are observable but not needed here
    always_comb begin
        acc_unused = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            acc_unused = acc_unused ^ (^lane_acc[l]);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        matmul_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .OUT_WIDTH  (OUT_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .clear        (lane_clear),
            .enable       (calc),
            .signed_mode  (mode_q),
            .a            (a_sel),
            .b            (b_sel[l]),
            .acc          (lane_acc[l]),
            .result       (lane_res[l]),
            .out_of_range (lane_oor[l])
        );
    end

    // Result store: written element by element; untouched elements keep the previous job's values
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (wr_en) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                result_q[res_idx[l] +: OUT_WIDTH] <= lane_res[l];
            end
        end
    end

    // Sticky overflow, cleared only by an accepted start
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            overflow_q <= 1'b0;
        end else if (wr_en && (|lane_oor)) begin
            overflow_q <= 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign result_c = result_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: vector table on small shapes, randomized 4x4 jobs against a reference model,
// and hand-written control sequences (mid-job start, mid-job operand change, reset mid-CALC, back-to-back jobs).
module tb_matmul_engine;

`ifdef MATMUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         sig_mode;
    logic [4:0]   start_v;
    logic [4:0]   busy_v;
    logic [4:0]   done_v;
    logic [4:0]   ovf_v;
    logic [127:0] ma, mb;
    logic [255:0] c0, c1;
    logic [31:0]  a_tab, b_tab;
    logic [63:0]  c2;
    logic [7:0]   c3;
    logic [15:0]  c4;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matmul_engine #(.DATA_WIDTH(8), .M(4), .N(4), .P(4), .LANES(1), .OUT_WIDTH(16)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sig_mode),
        .matrix_a(ma), .matrix_b(mb), .busy(busy_v[0]), .done(done_v[0]),
        .overflow(ovf_v[0]), .result_c(c0));

    matmul_engine #(.DATA_WIDTH(8), .M(4), .N(4), .P(4), .LANES(4), .OUT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sig_mode),
        .matrix_a(ma), .matrix_b(mb), .busy(busy_v[1]), .done(done_v[1]),
        .overflow(ovf_v[1]), .result_c(c1));

    matmul_engine #(.DATA_WIDTH(8), .M(2), .N(2), .P(2), .LANES(1), .OUT_WIDTH(16)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sig_mode),
        .matrix_a(a_tab), .matrix_b(b_tab), .busy(busy_v[2]), .done(done_v[2]),
        .overflow(ovf_v[2]), .result_c(c2));

    matmul_engine #(.DATA_WIDTH(8), .M(1), .N(2), .P(1), .LANES(1), .OUT_WIDTH(8)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sig_mode),
        .matrix_a(a_tab[15:0]), .matrix_b(b_tab[15:0]), .busy(busy_v[3]), .done(done_v[3]),
        .overflow(ovf_v[3]), .result_c(c3));

    matmul_engine #(.DATA_WIDTH(8), .M(1), .N(1), .P(1), .LANES(1), .OUT_WIDTH(16)) u4 (
        .clk(clk), .rst(rst), .start(start_v[4]), .signed_mode(sig_mode),
        .matrix_a(a_tab[7:0]), .matrix_b(b_tab[7:0]), .busy(busy_v[4]), .done(done_v[4]),
        .overflow(ovf_v[4]), .result_c(c4));

    typedef struct {
        int          inst;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count cycles from the start edge to the done pulse
    task automatic run_job(input int idx, output int lat);
        lat = -1;
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (done_v[idx]) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic logic [63:0] tab_c(input int inst);
        case (inst)
            2:       return c2;
            3:       return {56'b0, c3};
            default: return {48'b0, c4};
        endcase
    endfunction

    task automatic fill_rand(input int lo, input int hi);
        for (int e = 0; e < 16; e++) begin
            ma[e*8 +: 8] = 8'($urandom_range(hi, lo));
            mb[e*8 +: 8] = 8'($urandom_range(hi, lo));
        end
    endtask

    // Reference 4x4 product with 16-bit narrowing, straight from the arithmetic definition
    task automatic ref_mm(input logic [127:0] a, input logic [127:0] b, input logic sgn,
                          output logic [255:0] c, output logic ovf);
        longint      s, x, y, lo, hi, so;
        logic [7:0]  ea, eb;
        logic [63:0] sv;
        c   = '0;
        ovf = 1'b0;
        lo  = sgn ? -32768 : 0;
        hi  = sgn ? 32767 : 65535;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    ea = a[(r*4+k)*8 +: 8];
                    eb = b[(k*4+col)*8 +: 8];
                    if (sgn) begin
                        x = longint'($signed(ea));
                        y = longint'($signed(eb));
                    end else begin
                        x = longint'(ea);
                        y = longint'(eb);
                    end
                    s += x * y;
                end
                if (s > hi || s < lo) ovf = 1'b1;
                so = s;
                if (SAT && s > hi) so = hi;
                if (SAT && s < lo) so = lo;
                sv = so;
                c[(r*4+col)*16 +: 16] = sv[15:0];
            end
        end
    endtask

    initial begin
        vec_t         tbl [9];
        int           lat;
        logic [255:0] exp1, exp2;
        logic         eo1, eo2;

        rst = 1'b1; sig_mode = 1'b0; start_v = '0;
        ma = '0; mb = '0; a_tab = '0; b_tab = '0;

        tbl[0] = '{2, 1'b0, 32'h04030201, 32'h08070605, 64'h0032_002B_0016_0013, 1'b0, 9};
        tbl[1] = '{2, 1'b1, 32'hFC0302FF, 32'h0807FA05, 64'hFFCE_FFF3_0016_0009, 1'b0, 9};
        tbl[2] = '{2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFC02_FC02_FC02_FC02, 1'b1, 9};
        tbl[3] = '{3, 1'b1, 32'h00008080, 32'h00008080, SAT ? 64'h7F : 64'h00, 1'b1, 3};
        tbl[4] = '{3, 1'b1, 32'h00000180, 32'h0000FF01, SAT ? 64'h80 : 64'h7F, 1'b1, 3};
        tbl[5] = '{3, 1'b0, 32'h00000F10, 32'h00000108, 64'h8F, 1'b0, 3};
        tbl[6] = '{3, 1'b1, 32'h00000F10, 32'h00000108, SAT ? 64'h7F : 64'h8F, 1'b1, 3};
        tbl[7] = '{4, 1'b0, 32'h000000FF, 32'h000000FF, 64'hFE01, 1'b0, 2};
        tbl[8] = '{4, 1'b1, 32'h000000FF, 32'h000000FF, 64'h0001, 1'b0, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 256'(busy_v), 256'(0));
        check("reset_done", 256'(done_v), 256'(0));
        check("reset_ovf", 256'(ovf_v), 256'(0));
        check("reset_c0", c0, 256'(0));

        // Vector table on the small shapes
        for (int t = 0; t < 9; t++) begin
            a_tab    = tbl[t].a;
            b_tab    = tbl[t].b;
            sig_mode = tbl[t].mode;
            run_job(tbl[t].inst, lat);
            check($sformatf("tbl%0d_lat", t), 256'(lat), 256'(tbl[t].lat));
            check($sformatf("tbl%0d_c", t), 256'(tab_c(tbl[t].inst)), 256'(tbl[t].c));
            check($sformatf("tbl%0d_ovf", t), 256'(ovf_v[tbl[t].inst]), 256'(tbl[t].ovf));
        end

        // Random 4x4 jobs, one lane versus four lanes
        for (int t = 0; t < 4; t++) begin
            if (t == 0) fill_rand(0, 15); else fill_rand(0, 255);
            sig_mode = 1'($urandom_range(1, 0));
            ref_mm(ma, mb, sig_mode, exp1, eo1);
            run_job(0, lat);
            check($sformatf("rnd%0d_l1_lat", t), 256'(lat), 256'(65));
            check($sformatf("rnd%0d_l1_c", t), c0, exp1);
            check($sformatf("rnd%0d_l1_ovf", t), 256'(ovf_v[0]), 256'(eo1));
            run_job(1, lat);
            check($sformatf("rnd%0d_l4_lat", t), 256'(lat), 256'(17));
            check($sformatf("rnd%0d_l4_c", t), c1, exp1);
            check($sformatf("rnd%0d_l4_ovf", t), 256'(ovf_v[1]), 256'(eo1));
        end

        // Start pulsed mid-CALC and operands changed mid-job
        fill_rand(128, 255);
        sig_mode = 1'b0;
        ref_mm(ma, mb, 1'b0, exp1, eo1);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        ma = ~ma;
        lat = -1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            start_v[0] = (n == 10);
            if (done_v[0]) begin
                lat = n;
                break;
            end
        end
        start_v[0] = 1'b0;
        check("midstart_lat", 256'(lat), 256'(65));
        check("midchange_c", c0, exp1);
        check("midchange_ovf", 256'(ovf_v[0]), 256'(eo1));
        @(negedge clk);
        check("done_one_cycle", 256'(done_v[0]), 256'(0));
        check("busy_after_done", 256'(busy_v[0]), 256'(0));

        // Reset at CALC cycle 3, then a clean job
        fill_rand(0, 255);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_in_calc", 256'(busy_v[0]), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 256'(busy_v[0]), 256'(0));
        check("rst_done", 256'(done_v[0]), 256'(0));
        check("rst_ovf", 256'(ovf_v[0]), 256'(0));
        check("rst_c", c0, 256'(0));
        fill_rand(0, 255);
        sig_mode = 1'b1;
        ref_mm(ma, mb, 1'b1, exp1, eo1);
        run_job(0, lat);
        check("postrst_lat", 256'(lat), 256'(65));
        check("postrst_c", c0, exp1);
        check("postrst_ovf", 256'(ovf_v[0]), 256'(eo1));

        // Back-to-back: start held high, second job accepted right after done
        ma = '1; mb = '1; sig_mode = 1'b0;
        ref_mm(ma, mb, 1'b0, exp1, eo1);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        fill_rand(0, 15);
        ref_mm(ma, mb, 1'b0, exp2, eo2);
        lat = -1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (done_v[0]) begin
                lat = n;
                break;
            end
        end
        check("b2b_lat1", 256'(lat), 256'(65));
        check("b2b_c1", c0, exp1);
        check("b2b_ovf1", 256'(ovf_v[0]), 256'(eo1));
        @(negedge clk);
        check("b2b_ovf_clear", 256'(ovf_v[0]), 256'(0));
        lat = -1;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (done_v[0]) begin
                lat = n;
                break;
            end
        end
        start_v[0] = 1'b0;
        check("b2b_lat2", 256'(lat), 256'(65));
        check("b2b_c2", c0, exp2);
        check("b2b_ovf2", 256'(ovf_v[0]), 256'(eo2));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
